// File: rtl/instr_decode_stage_if.sv
// Fetch-to-decode bus: instruction/PC push handshake plus the decoded head entry
// and the pop handshake. The slave modport is the decode stage's view.
interface instr_decode_stage_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           instr;
  logic [ADDR_WIDTH-1:0] pc;

  logic                  out_valid;
  logic                  out_ready;
  logic [5:0]            opcode;
  logic [4:0]            rs;
  logic [4:0]            rt;
  logic [4:0]            rd;
  logic [4:0]            shamt;
  logic [5:0]            funct;
  logic [31:0]           imm_ext;
  logic [ADDR_WIDTH-1:0] jump_target;
  logic [1:0]            instr_type;
  logic [4:0]            dest_reg;
  logic [ADDR_WIDTH-1:0] pc_out;
  logic [CW-1:0]         count;

  modport slave (
    input  in_valid, instr, pc, out_ready,
    output in_ready, out_valid, opcode, rs, rt, rd, shamt, funct,
           imm_ext, jump_target, instr_type, dest_reg, pc_out, count
  );

  modport master (
    output in_valid, instr, pc, out_ready,
    input  in_ready, out_valid, opcode, rs, rt, rd, shamt, funct,
           imm_ext, jump_target, instr_type, dest_reg, pc_out, count
  );
endinterface

// File: rtl/instr_decode_stage.sv
// Buffered MIPS decode: DEPTH-entry FIFO of {instr, pc}, head shown decoded one cycle after push.
// in_ready comes only from registered occupancy (no path from out_ready); flush/reset empty the queue.

module instr_decode_stage_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdat_i,
  output logic [WIDTH-1:0]           rdat_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the wrap to 0
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdat_i;
  end

  assign rdat_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

module instr_decode_stage #(
  parameter int DEPTH          = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter bit ZERO_EXT_LOGIC = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  instr_decode_stage_if.slave   bus
);
  localparam int EW = 32 + ADDR_WIDTH;

  typedef enum logic [1:0] {
    ITYPE_R = 2'b00,
    ITYPE_I = 2'b01,
    ITYPE_J = 2'b10
  } itype_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  logic                  push, pop, full, empty;
  logic [EW-1:0]         head;
  logic [31:0]           head_instr;
  logic [ADDR_WIDTH-1:0] head_pc;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] jt_raw;
  logic [5:0]            op;
  logic                  zext;
  itype_e                itype;

  assign push         = bus.in_valid && !full;
  assign pop          = bus.out_ready && !empty;
  assign bus.in_ready = !full;
  assign bus.out_valid = !empty;

  instr_decode_stage_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdat_i  ({bus.instr, bus.pc}),
    .rdat_o  (head),
    .count_o (bus.count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign head_instr = head[EW-1:ADDR_WIDTH];
  assign head_pc    = head[ADDR_WIDTH-1:0];
  assign pc_plus4   = head_pc + ADDR_WIDTH'(4);
  assign op         = head_instr[31:26];

  // Region bits above the 256 MB jump window come from pc+4 of the head entry
  generate
    if (ADDR_WIDTH > 28) begin : g_jt_region
      assign jt_raw = {pc_plus4[ADDR_WIDTH-1:28], head_instr[25:0], 2'b00};
    end else begin : g_jt_flat
      assign jt_raw = {head_instr[25:0], 2'b00};
    end
  endgenerate

  assign zext = ZERO_EXT_LOGIC && ((op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI));

  always_comb begin
    if (op == OP_RTYPE)                     itype = ITYPE_R;
    else if ((op == OP_J) || (op == OP_JAL)) itype = ITYPE_J;
    else                                    itype = ITYPE_I;
  end

  // Every decoded field is held at zero while nothing valid is at the head
  always_comb begin
    bus.opcode      = '0;
    bus.rs          = '0;
    bus.rt          = '0;
    bus.rd          = '0;
    bus.shamt       = '0;
    bus.funct       = '0;
    bus.imm_ext     = '0;
    bus.jump_target = '0;
    bus.instr_type  = '0;
    bus.dest_reg    = '0;
    bus.pc_out      = '0;
    if (!empty) begin
      bus.opcode      = op;
      bus.rs          = head_instr[25:21];
      bus.rt          = head_instr[20:16];
      bus.rd          = head_instr[15:11];
      bus.shamt       = head_instr[10:6];
      bus.funct       = head_instr[5:0];
      bus.imm_ext     = zext ? {16'h0000, head_instr[15:0]}
                             : {{16{head_instr[15]}}, head_instr[15:0]};
      bus.jump_target = jt_raw;
      bus.instr_type  = itype;
      bus.pc_out      = head_pc;
      case (itype)
        ITYPE_R: bus.dest_reg = head_instr[15:11];
        ITYPE_I: bus.dest_reg = head_instr[20:16];
        default: bus.dest_reg = (op == OP_JAL) ? 5'd31 : 5'd0;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench: decode vector table on a sign/zero-extend DUT pair, then
// backpressure, streaming, flush and asynchronous-reset sequences.
module tb_instr_decode_stage;
  localparam int AW = 32;
  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic [31:0] imm;
    logic [31:0] imm_se;
    logic [31:0] jt;
    logic [1:0]  ty;
    logic [4:0]  dst;
  } vec_t;

  logic clk;
  logic rst_n;
  logic flush;
  int   checks;
  int   errors;
  vec_t vecs [9];

  instr_decode_stage_if #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) bus0 ();
  instr_decode_stage_if #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) bus1 ();

  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.instr     = bus0.instr;
  assign bus1.pc        = bus0.pc;
  assign bus1.out_ready = bus0.out_ready;

  instr_decode_stage #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .ZERO_EXT_LOGIC(1'b1)) u_dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .bus     (bus0)
  );

  instr_decode_stage #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .ZERO_EXT_LOGIC(1'b0)) u_dut_se (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .bus     (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input vec_t v);
    bus0.in_valid = 1'b1;
    bus0.instr    = v.instr;
    bus0.pc       = v.pc;
  endtask

  task automatic idle_in();
    bus0.in_valid = 1'b0;
    bus0.instr    = '0;
    bus0.pc       = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".out_valid"}, 32'(bus0.out_valid), 32'd0);
    chk({tag, ".in_ready"},  32'(bus0.in_ready),  32'd1);
    chk({tag, ".count"},     32'(bus0.count),     32'd0);
    chk({tag, ".opcode"},    32'(bus0.opcode),    32'd0);
    chk({tag, ".dest_reg"},  32'(bus0.dest_reg),  32'd0);
    chk({tag, ".imm_ext"},   bus0.imm_ext,        32'd0);
    chk({tag, ".jt"},        bus0.jump_target,    32'd0);
    chk({tag, ".pc_out"},    bus0.pc_out,         32'd0);
  endtask

  task automatic chk_head(input string tag, input vec_t v);
    chk({tag, ".out_valid"}, 32'(bus0.out_valid),  32'd1);
    chk({tag, ".opcode"},    32'(bus0.opcode),     32'(v.op));
    chk({tag, ".rs"},        32'(bus0.rs),         32'(v.rs));
    chk({tag, ".rt"},        32'(bus0.rt),         32'(v.rt));
    chk({tag, ".rd"},        32'(bus0.rd),         32'(v.rd));
    chk({tag, ".shamt"},     32'(bus0.shamt),      32'(v.sh));
    chk({tag, ".funct"},     32'(bus0.funct),      32'(v.fn));
    chk({tag, ".imm_ext"},   bus0.imm_ext,         v.imm);
    chk({tag, ".imm_se"},    bus1.imm_ext,         v.imm_se);
    chk({tag, ".jt"},        bus0.jump_target,     v.jt);
    chk({tag, ".type"},      32'(bus0.instr_type), 32'(v.ty));
    chk({tag, ".dest_reg"},  32'(bus0.dest_reg),   32'(v.dst));
    chk({tag, ".pc_out"},    bus0.pc_out,          v.pc);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    //            instr         pc            op     rs     rt     rd     sh     fn     imm           imm_se        jt            ty     dst
    vecs[0] = '{32'h21290004, 32'h00400000, 6'h08, 5'd9,  5'd9,  5'd0,  5'd0,  6'h04, 32'h00000004, 32'h00000004, 32'h04A40010, 2'b01, 5'd9};
    vecs[1] = '{32'h012A4020, 32'h00400004, 6'h00, 5'd9,  5'd10, 5'd8,  5'd0,  6'h20, 32'h00004020, 32'h00004020, 32'h04A90080, 2'b00, 5'd8};
    vecs[2] = '{32'h2129FFFC, 32'h00400008, 6'h08, 5'd9,  5'd9,  5'd31, 5'd31, 6'h3C, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h04A7FFF0, 2'b01, 5'd9};
    vecs[3] = '{32'h3129FFFF, 32'h0040000C, 6'h0C, 5'd9,  5'd9,  5'd31, 5'd31, 6'h3F, 32'h0000FFFF, 32'hFFFFFFFF, 32'h04A7FFFC, 2'b01, 5'd9};
    vecs[4] = '{32'h0C100004, 32'h00400000, 6'h03, 5'd0,  5'd16, 5'd0,  5'd0,  6'h04, 32'h00000004, 32'h00000004, 32'h00400010, 2'b10, 5'd31};
    vecs[5] = '{32'h08100004, 32'h00400000, 6'h02, 5'd0,  5'd16, 5'd0,  5'd0,  6'h04, 32'h00000004, 32'h00000004, 32'h00400010, 2'b10, 5'd0};
    vecs[6] = '{32'h0BFFFFFF, 32'hAFFFFFFC, 6'h02, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hBFFFFFFC, 2'b10, 5'd0};
    vecs[7] = '{32'h0C000001, 32'hFFFFFFFC, 6'h03, 5'd0,  5'd0,  5'd0,  5'd0,  6'h01, 32'h00000001, 32'h00000001, 32'h00000004, 2'b10, 5'd31};
    vecs[8] = '{32'h38A5800F, 32'h00000010, 6'h0E, 5'd5,  5'd5,  5'd16, 5'd0,  6'h0F, 32'h0000800F, 32'hFFFF800F, 32'h0296003C, 2'b01, 5'd5};

    rst_n = 1'b0;
    flush = 1'b0;
    bus0.out_ready = 1'b0;
    idle_in();
    #2;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Decode table: one instruction at a time through an empty queue
    for (int i = 0; i < 9; i++) begin
      offer(vecs[i]);
      bus0.out_ready = 1'b0;
      #1;
      chk($sformatf("vec%0d.no_bypass", i), 32'(bus0.out_valid), 32'd0);
      step();
      idle_in();
      chk($sformatf("vec%0d.count", i), 32'(bus0.count), 32'd1);
      chk_head($sformatf("vec%0d", i), vecs[i]);
      bus0.out_ready = 1'b1;
      step();
      bus0.out_ready = 1'b0;
      chk($sformatf("vec%0d.drained", i), 32'(bus0.out_valid), 32'd0);
    end

    // Backpressure: fill, offer C while full, then pop with C still offered
    offer(vecs[0]);
    step();
    offer(vecs[1]);
    step();
    chk("bp.count_full", 32'(bus0.count), 32'd2);
    chk("bp.in_ready_full", 32'(bus0.in_ready), 32'd0);
    offer(vecs[2]);
    step();
    chk("bp.count_hold", 32'(bus0.count), 32'd2);
    chk_head("bp.hold_A", vecs[0]);
    bus0.out_ready = 1'b1;
    #1;
    chk("bp.in_ready_on_pop", 32'(bus0.in_ready), 32'd0);
    step();
    idle_in();
    chk("bp.count_after_pop", 32'(bus0.count), 32'd1);
    chk_head("bp.then_B", vecs[1]);
    step();
    bus0.out_ready = 1'b0;
    chk("bp.empty", 32'(bus0.out_valid), 32'd0);

    // Streaming: push and pop every cycle, occupancy stays at one
    bus0.out_ready = 1'b1;
    offer(vecs[0]);
    step();
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("stream%0d.count", i), 32'(bus0.count), 32'd1);
      chk($sformatf("stream%0d.in_ready", i), 32'(bus0.in_ready), 32'd1);
      chk($sformatf("stream%0d.pc", i), bus0.pc_out, vecs[i-1].pc);
      chk($sformatf("stream%0d.op", i), 32'(bus0.opcode), 32'(vecs[i-1].op));
      offer(vecs[i]);
      step();
    end
    idle_in();
    chk_head("stream.last", vecs[3]);
    step();
    bus0.out_ready = 1'b0;
    chk("stream.empty", 32'(bus0.out_valid), 32'd0);

    // Flush with a full queue and a simultaneous push
    offer(vecs[0]);
    step();
    offer(vecs[1]);
    step();
    chk("flush.pre_count", 32'(bus0.count), 32'd2);
    offer(vecs[2]);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle_in();
    chk_zero("flush");
    offer(vecs[4]);
    step();
    idle_in();
    chk("flush.repush_count", 32'(bus0.count), 32'd1);
    chk_head("flush.repush", vecs[4]);
    bus0.out_ready = 1'b1;
    step();
    bus0.out_ready = 1'b0;

    // Asynchronous reset in the middle of a cycle with entries queued
    offer(vecs[0]);
    step();
    offer(vecs[1]);
    step();
    idle_in();
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("arst");
    @(negedge clk);
    rst_n = 1'b1;
    offer(vecs[5]);
    step();
    idle_in();
    chk("arst.repush_count", 32'(bus0.count), 32'd1);
    chk_head("arst.repush", vecs[5]);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
